// File: rtl/slurm16_cpu_hazard_ctrl.sv
// Stall/bubble sequencer and hazard scoreboard for the slurm16 four-stage pipeline.
// Optional stall performance counter: define SLURM16_HAZARD_PERF_EN.
module slurm16_cpu_hazard_ctrl #(
  parameter int REGISTER_BITS  = 4,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [REGISTER_BITS-1:0]  hazard_reg0,
  input  logic                      modifies_flags0,
  input  logic                      hazard_1,
  input  logic                      hazard_2,
  input  logic                      hazard_3,
  input  logic                      mem_wait,
  input  logic                      flush,
  input  logic                      perf_clr,
  output logic [REGISTER_BITS-1:0]  hazard_reg1,
  output logic [REGISTER_BITS-1:0]  hazard_reg2,
  output logic [REGISTER_BITS-1:0]  hazard_reg3,
  output logic                      modifies_flags1,
  output logic                      modifies_flags2,
  output logic                      modifies_flags3,
  output logic                      stall_p0,
  output logic                      bubble_p1,
  output logic                      freeze,
  output logic [STALL_CNT_BITS-1:0] stall_cycles,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL      = 2'd1,
    FLUSH_PEND = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       any_haz;
  logic       flush_eff;
  logic       stall_act;
  logic [1:0] stall_len;

  // A producer must leave slot 3 before the consumer advances: length is 4-k for lowest k.
  assign any_haz   = hazard_1 | hazard_2 | hazard_3;
  assign stall_len = hazard_1 ? 2'd3 : (hazard_2 ? 2'd2 : 2'd1);
  assign flush_eff = !mem_wait && (flush || (state == FLUSH_PEND));
  assign stall_act = !RST && !mem_wait && !flush_eff &&
                     ((state == STALL) || ((state == RUN) && any_haz));

  assign stall_p0  = stall_act;
  assign bubble_p1 = stall_act;
  assign freeze    = !RST && mem_wait;
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= RUN;
      cnt             <= 2'd0;
      hazard_reg1     <= '0;
      hazard_reg2     <= '0;
      hazard_reg3     <= '0;
      modifies_flags1 <= 1'b0;
      modifies_flags2 <= 1'b0;
      modifies_flags3 <= 1'b0;
    end else if (mem_wait) begin
      // Everything holds; a flush seen now is remembered and applied on release.
      if (flush) state <= FLUSH_PEND;
    end else if (flush_eff) begin
      hazard_reg3     <= hazard_reg2;
      hazard_reg2     <= '0;
      hazard_reg1     <= '0;
      modifies_flags3 <= modifies_flags2;
      modifies_flags2 <= 1'b0;
      modifies_flags1 <= 1'b0;
      cnt             <= 2'd0;
      state           <= RUN;
    end else begin
      hazard_reg3     <= hazard_reg2;
      hazard_reg2     <= hazard_reg1;
      modifies_flags3 <= modifies_flags2;
      modifies_flags2 <= modifies_flags1;
      hazard_reg1     <= stall_act ? '0 : hazard_reg0;
      modifies_flags1 <= stall_act ? 1'b0 : modifies_flags0;
      case (state)
        RUN: begin
          if (any_haz) begin
            cnt   <= stall_len - 2'd1;
            state <= (stall_len > 2'd1) ? STALL : RUN;
          end
        end
        STALL: begin
          if (cnt <= 2'd1) begin
            cnt   <= 2'd0;
            state <= RUN;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          cnt   <= 2'd0;
          state <= RUN;
        end
      endcase
    end
  end

`ifdef SLURM16_HAZARD_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if ((stall_p0 || freeze) && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = '0;
`endif

endmodule
